// File: rtl/fet_queue_if.sv
// fet_queue_if -- fetch-unit bus bundle.
// Groups the redirect/halt controls, the instruction-memory read port and
// the decode-side handshake of the fetch queue.
//   master : the fetch queue (drives o_* signals, receives i_* signals)
//   slave  : the surrounding core / memory / testbench
// DEPTH must match the fet_queue instance (sizes o_count).
interface fet_queue_if #(
    parameter int unsigned DEPTH = 4
);
    logic                     i_redirect;
    logic [31:0]              i_redirect_pc;
    logic                     i_halt;
    logic                     o_imem_ren;
    logic [31:0]              o_imem_raddr;
    logic [31:0]              i_imem_rdata;
    logic                     o_vld;
    logic                     i_rdy;
    logic [31:0]              o_inst;
    logic [31:0]              o_pc;
    logic [31:0]              o_nxt_pc;
    logic [$clog2(DEPTH):0]   o_count;

    modport master (
        input  i_redirect, i_redirect_pc, i_halt, i_imem_rdata, i_rdy,
        output o_imem_ren, o_imem_raddr, o_vld, o_inst, o_pc, o_nxt_pc, o_count
    );

    modport slave (
        output i_redirect, i_redirect_pc, i_halt, i_imem_rdata, i_rdy,
        input  o_imem_ren, o_imem_raddr, o_vld, o_inst, o_pc, o_nxt_pc, o_count
    );
endinterface

// File: rtl/fet_queue.sv
// fet_queue -- instruction fetch unit with a small instruction queue.
// Issues sequential reads to instruction memory (1-cycle read latency),
// pushes {pc, inst} pairs into a circular queue and presents the head to
// decode through a valid/ready handshake. A redirect flushes the queue and
// kills the in-flight response; halt stops new requests only.
// Ports:
//   i_clk  : clock, all state updates on the rising edge
//   i_rst  : synchronous active-high reset
//   bus    : fet_queue_if.master (redirect/halt, imem read port, decode side)
module fet_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic           i_clk,
    input  logic           i_rst,
    fet_queue_if.master    bus
);
    localparam int unsigned PW      = $clog2(DEPTH);
    localparam int unsigned CW      = PW + 1;
    localparam logic [31:0] NOP     = 32'h0000_0033;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_STALL,
        ST_REDIRECT
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [31:0]     fpc;
    logic [31:0]     req_pc;
    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [31:0]     inst_mem [DEPTH];
    logic [31:0]     pc_mem   [DEPTH];
    logic            inflight;
    logic            push;
    logic            pop;
    logic            ren;
    logic [CW:0]     occupancy;

    // state_d classifies the current cycle; state_q is last cycle's class.
    // A request went out last cycle exactly when that cycle was ISSUE, so
    // the registered state doubles as the in-flight flag (a redirect cycle
    // never issues, so there is no killed request to track separately).
    assign inflight = (state_q == ST_ISSUE);

    always_comb begin
        occupancy = {1'b0, count} + (CW + 1)'(inflight);
        state_d   = ST_ISSUE;
        if (bus.i_redirect) begin
            state_d = ST_REDIRECT;
        end else if (bus.i_halt) begin
            state_d = ST_IDLE;
        end else if (occupancy >= DEPTH_W) begin
            // A pop this cycle is deliberately not counted as free space.
            state_d = ST_STALL;
        end
    end

    assign ren  = !i_rst && (state_d == ST_ISSUE);
    assign push = inflight && !bus.i_redirect;
    assign pop  = bus.o_vld && bus.i_rdy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            fpc     <= RESET_ADDR;
            req_pc  <= RESET_ADDR;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                inst_mem[i] <= NOP;
                pc_mem[i]   <= RESET_ADDR;
            end
        end else begin
            state_q <= state_d;
            if (bus.i_redirect) begin
                // Flush: response arriving now is dropped, queue empties.
                fpc    <= {bus.i_redirect_pc[31:2], 2'b00};
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (ren) begin
                    fpc    <= fpc + 32'd4;
                    req_pc <= fpc;
                end
                if (push) begin
                    inst_mem[wr_ptr] <= bus.i_imem_rdata;
                    pc_mem[wr_ptr]   <= req_pc;
                    wr_ptr           <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    assign bus.o_imem_ren   = ren;
    assign bus.o_imem_raddr = fpc;
    assign bus.o_vld        = (count != '0);
    assign bus.o_inst       = inst_mem[rd_ptr];
    assign bus.o_pc         = pc_mem[rd_ptr];
    assign bus.o_nxt_pc     = pc_mem[rd_ptr] + 32'd4;
    assign bus.o_count      = count;
endmodule

// File: tb/tb_fet_queue.sv
// tb_fet_queue -- directed self-checking bench for fet_queue (DEPTH=4).
// Instruction memory returns (address ^ K) one cycle after each read so
// instruction and pc values are distinguishable.
module tb_fet_queue;
    localparam logic [31:0] K = 32'hDEAD_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    fet_queue_if #(.DEPTH(4)) bus ();

    fet_queue #(.DEPTH(4), .RESET_ADDR(32'h0000_0000)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        bus.i_imem_rdata <= bus.o_imem_ren ? (bus.o_imem_raddr ^ K) : 32'h0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, "_vld"}, 32'(bus.o_vld), 32'd1);
        check({tag, "_pc"}, bus.o_pc, pc);
        check({tag, "_inst"}, bus.o_inst, pc ^ K);
        check({tag, "_nxt"}, bus.o_nxt_pc, pc + 32'd4);
    endtask

    // Leaves the bench 2 time units after a posedge with i_rst just released.
    task automatic do_reset;
        rst               = 1'b1;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = 32'h0;
        bus.i_halt        = 1'b0;
        bus.i_rdy         = 1'b0;
        tick;
        tick;
        #1;
        check("rst_vld", 32'(bus.o_vld), 32'd0);
        check("rst_count", 32'(bus.o_count), 32'd0);
        check("rst_ren", 32'(bus.o_imem_ren), 32'd0);
        check("rst_inst", bus.o_inst, 32'h0000_0033);
        check("rst_pc", bus.o_pc, 32'h0);
        rst = 1'b0;
    endtask

    int bp_count [11] = '{0, 0, 1, 2, 3, 4, 3, 2, 2, 2, 2};

    initial begin
        // Streaming: one request per cycle, head valid from cycle 2.
        do_reset();
        bus.i_rdy = 1'b1;
        for (int n = 0; n < 8; n++) begin
            if (n > 0) tick;
            #1;
            check("str_ren", 32'(bus.o_imem_ren), 32'd1);
            check("str_addr", bus.o_imem_raddr, 32'(4 * n));
            if (n >= 2) check_head("str", 32'(4 * (n - 2)));
            else        check("str_vld0", 32'(bus.o_vld), 32'd0);
        end

        // Backpressure: fill to DEPTH, then drain without loss/duplication.
        do_reset();
        for (int n = 0; n < 11; n++) begin
            if (n > 0) tick;
            if (n == 5) bus.i_rdy = 1'b1;
            #1;
            check("bp_count", 32'(bus.o_count), 32'(bp_count[n]));
            check("bp_ren", 32'(bus.o_imem_ren), 32'((n < 4) || (n >= 6)));
            if (n < 4)  check("bp_addr", bus.o_imem_raddr, 32'(4 * n));
            if (n >= 6) check("bp_addr", bus.o_imem_raddr, 32'(16 + 4 * (n - 6)));
            if (n >= 5) check_head("bp", 32'(4 * (n - 5)));
        end

        // Redirect with 3 queued + 1 in flight.
        do_reset();
        for (int n = 0; n < 4; n++) begin
            if (n > 0) tick;
            #1;
        end
        tick;
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 32'h0000_0103;
        #1;
        check("rd_count3", 32'(bus.o_count), 32'd3);
        check("rd_ren0", 32'(bus.o_imem_ren), 32'd0);
        tick;
        bus.i_redirect = 1'b0;
        bus.i_rdy      = 1'b1;
        #1;
        check("rd_count0", 32'(bus.o_count), 32'd0);
        check("rd_vld0", 32'(bus.o_vld), 32'd0);
        check("rd_ren1", 32'(bus.o_imem_ren), 32'd1);
        check("rd_addr", bus.o_imem_raddr, 32'h0000_0100);
        tick; #1;
        check("rd_addr2", bus.o_imem_raddr, 32'h0000_0104);
        check("rd_vld1", 32'(bus.o_vld), 32'd0);
        tick; #1;
        check_head("rd", 32'h0000_0100);

        // Halt with one request in flight.
        do_reset();
        bus.i_rdy = 1'b1;
        #1;
        check("h_ren0", 32'(bus.o_imem_ren), 32'd1);
        check("h_addr0", bus.o_imem_raddr, 32'h0);
        tick;
        bus.i_halt = 1'b1;
        #1;
        check("h_ren1", 32'(bus.o_imem_ren), 32'd0);
        tick; #1;
        check_head("h", 32'h0);
        check("h_ren2", 32'(bus.o_imem_ren), 32'd0);
        tick; #1;
        check("h_vld3", 32'(bus.o_vld), 32'd0);
        check("h_ren3", 32'(bus.o_imem_ren), 32'd0);
        tick;
        bus.i_halt = 1'b0;
        #1;
        check("h_ren4", 32'(bus.o_imem_ren), 32'd1);
        check("h_addr4", bus.o_imem_raddr, 32'h4);
        tick; #1;
        check("h_addr5", bus.o_imem_raddr, 32'h8);
        tick; #1;
        check_head("h_res", 32'h4);

        // Redirect while halted to a wrapping address (low bits dropped).
        do_reset();
        bus.i_rdy         = 1'b1;
        bus.i_halt        = 1'b1;
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 32'hFFFF_FFFA;
        #1;
        check("w_ren0", 32'(bus.o_imem_ren), 32'd0);
        tick;
        bus.i_halt     = 1'b0;
        bus.i_redirect = 1'b0;
        #1;
        check("w_addr1", bus.o_imem_raddr, 32'hFFFF_FFF8);
        tick; #1;
        check("w_addr2", bus.o_imem_raddr, 32'hFFFF_FFFC);
        tick; #1;
        check("w_addr3", bus.o_imem_raddr, 32'h0000_0000);
        check_head("w3", 32'hFFFF_FFF8);
        tick; #1;
        check_head("w4", 32'hFFFF_FFFC);
        check("w_nxt_wrap", bus.o_nxt_pc, 32'h0000_0000);
        tick; #1;
        check_head("w5", 32'h0000_0000);

        // Reset mid-stream with two entries queued.
        do_reset();
        #1;
        tick; #1;
        tick; #1;
        tick;
        rst = 1'b1;
        #1;
        check("mr_count2", 32'(bus.o_count), 32'd2);
        check("mr_ren", 32'(bus.o_imem_ren), 32'd0);
        tick; #1;
        check("mr_vld", 32'(bus.o_vld), 32'd0);
        check("mr_count", 32'(bus.o_count), 32'd0);
        check("mr_inst", bus.o_inst, 32'h0000_0033);
        rst = 1'b0;
        #1;
        check("mr_ren1", 32'(bus.o_imem_ren), 32'd1);
        check("mr_addr", bus.o_imem_raddr, 32'h0);
        tick; #1;
        check("mr_addr2", bus.o_imem_raddr, 32'h4);
        tick; #1;
        check_head("mr", 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/fet_queue.md
FET_QUEUE -- requirements
Module: fet_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set instruction-queue entries; legal values 2, 4, 8, 16.
REQ-002 Parameter RESET_ADDR, default 32'h00000000, SHALL set the first fetch address after reset; bits [1:0] SHALL be 0.
REQ-003 Port i_clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 Port i_rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 Port i_redirect  input  1  SHALL request a control-flow change (branch/jal/jalr/trap resolved downstream).
REQ-006 Port i_redirect_pc  input  32  SHALL be the redirect target address.
REQ-007 Port i_halt  input  1  SHALL stop issue of new fetch requests while high.
REQ-008 Port o_imem_ren  output  1  SHALL be the instruction-memory read strobe.
REQ-009 Port o_imem_raddr  output  32  SHALL be the read address, valid when o_imem_ren=1.
REQ-010 Port i_imem_rdata  input  32  SHALL be the read data, returned exactly one cycle after the o_imem_ren cycle.
REQ-011 Port o_vld  output  1  SHALL indicate the queue head holds a valid instruction.
REQ-012 Port i_rdy  input  1  SHALL indicate decode accepts the head; pop occurs when o_vld & i_rdy.
REQ-013 Port o_inst  output  32  SHALL be the head instruction.
REQ-014 Port o_pc  output  32  SHALL be the head instruction's address.
REQ-015 Port o_nxt_pc  output  32  SHALL be o_pc + 4, mod 2^32.
REQ-016 Port o_count  output  $clog2(DEPTH)+1  SHALL be the current number of queued entries.

Function
REQ-017 Fetch PC register fpc SHALL drive o_imem_raddr; fpc SHALL advance by 4 (wrapping at 2^32) on every cycle o_imem_ren=1.
REQ-018 o_imem_ren SHALL be 1 iff !i_rst & !i_halt & !i_redirect & (o_count + inflight + popping_unused... ) i.e. (o_count + inflight) < DEPTH, where inflight = 1 if a non-killed request was issued the previous cycle; pop in the same cycle SHALL NOT be counted as freeing space.
REQ-019 A response SHALL be pushed as {fpc_of_request, i_imem_rdata} the cycle after its request unless killed.
REQ-020 Queue SHALL be a circular buffer with wrapping read/write pointers; simultaneous push and pop SHALL leave o_count unchanged.
REQ-021 Push when o_count=DEPTH SHALL never occur (guaranteed by REQ-018); pop when o_count=0 SHALL never occur (o_vld=0).
REQ-022 o_vld SHALL equal (o_count != 0); o_inst/o_pc SHALL be registered head-entry values with zero combinational path from i_imem_rdata.
REQ-023 Pushed entries SHALL become visible at the head no earlier than the cycle after the push (fetch-to-decode latency 2 cycles from request when empty).
REQ-024 On i_redirect=1: queue SHALL empty (o_count=0, o_vld=0 next cycle), any response arriving in that cycle or from the request issued that cycle SHALL be discarded, fpc <= {i_redirect_pc[31:2],2'b00}, o_imem_ren=0 in that cycle.
REQ-025 Redirect SHALL take priority over push, pop and halt; a pop accepted by decode in the redirect cycle SHALL still count as consumed.
REQ-026 i_halt=1 SHALL NOT kill an in-flight response; queue SHALL drain normally; redirect while halted SHALL update fpc without issuing.
REQ-027 States per cycle SHALL be IDLE(halt), ISSUE, STALL(queue+inflight full), REDIRECT; transitions follow REQ-018/024/026 evaluated every cycle.

Reset
REQ-028 While i_rst=1: fpc=RESET_ADDR, queue empty, inflight=0, o_imem_ren=0, o_vld=0, o_count=0, o_inst=32'h00000033, o_pc=RESET_ADDR.
REQ-029 Reset asserted mid-operation SHALL discard queued and in-flight data; first request SHALL issue to RESET_ADDR on the first cycle i_rst=0 (if !i_halt).
REQ-030 All internal state SHALL have defined reset values; no X on any output after one reset cycle.

Verification
REQ-031 Streaming: DEPTH=4, i_rdy=1, rdata=addr -> o_imem_raddr 0,4,8,... one per cycle; o_vld from cycle 2; o_pc/o_inst 0,4,8 in order; o_nxt_pc=o_pc+4.
REQ-032 Backpressure: i_rdy=0 -> o_count reaches 4, o_imem_ren=0 in the cycle count+inflight=4; raise i_rdy -> no entry lost or duplicated.
REQ-033 Redirect: queue holding 3 entries, inflight=1, i_redirect=1 to 32'h00000103 -> next cycle o_count=0, o_vld=0, next request address 32'h00000100, discarded data never appears.
REQ-034 Halt: i_halt=1 with inflight=1 -> that response queued, no further o_imem_ren; release -> fetch resumes at next sequential address.
REQ-035 Wrap: redirect to 32'hFFFFFFF8 -> requests FFFFFFF8, FFFFFFFC, 00000000; o_nxt_pc for FFFFFFFC = 00000000.
REQ-036 Reset mid-stream with o_count=2 -> o_vld=0, o_count=0 during reset; first post-reset o_imem_raddr=RESET_ADDR.
